// File: rtl/digipot_wiper_sequencer_if.sv
// Command channel of the digipot wiper sequencer: valid/ready handshake carrying an op and tap data.
interface digipot_wiper_sequencer_if #(
  parameter int unsigned TAP_BITS = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [TAP_BITS-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/digipot_wiper_sequencer.sv
// Wiper controller for the digital potentiometer: ramps a one-hot tap enable toward a commanded
// target with break-before-make on every tap change and a programmable slew interval.
module digipot_wiper_sequencer #(
  parameter int unsigned TAP_BITS   = 4,
  parameter int unsigned STEP_DIV   = 1024,
  parameter int unsigned BBM_CYCLES = 4,
  localparam int unsigned NTAP      = 1 << TAP_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_ena,
  digipot_wiper_sequencer_if.slave    cmd,
  output logic [NTAP-1:0]             o_tap_en,
  output logic [TAP_BITS-1:0]         o_wiper_pos,
  output logic [TAP_BITS-1:0]         o_target,
  output logic                        o_busy,
  output logic                        o_at_target
);

  localparam int unsigned TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned BW = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
  localparam logic [TAP_BITS-1:0] TapMax  = {TAP_BITS{1'b1}};
  localparam logic [TAP_BITS-1:0] TapOne  = TAP_BITS'(1);
  localparam logic [NTAP-1:0]     OneHot0 = NTAP'(1);

  typedef enum logic [1:0] {StIdle, StWait, StBreak, StMake} state_e;

  localparam logic [1:0] OpSet  = 2'b00;
  localparam logic [1:0] OpInc  = 2'b01;
  localparam logic [1:0] OpDec  = 2'b10;
  localparam logic [1:0] OpJump = 2'b11;

  state_e              r_state;
  logic [TAP_BITS-1:0] r_pos;
  logic [TAP_BITS-1:0] r_target;
  logic [NTAP-1:0]     r_tap_en;
  logic [TW-1:0]       r_timer;
  logic [BW-1:0]       r_bbm;
  logic                r_jump;

  logic                w_ready;
  logic                w_accept;
  logic                w_is_jump;
  logic [TAP_BITS-1:0] w_cmd_target;
  logic [TAP_BITS-1:0] w_new_target;
  logic [TAP_BITS-1:0] w_step_pos;

  always_comb begin
    w_ready   = i_ena && ((r_state == StIdle) || (r_state == StWait));
    w_accept  = w_ready && cmd.cmd_valid;
    w_is_jump = w_accept && (cmd.cmd_op == OpJump);

    w_cmd_target = r_target;
    case (cmd.cmd_op)
      OpSet, OpJump: w_cmd_target = cmd.cmd_data;
      OpInc:         w_cmd_target = (r_target == TapMax) ? r_target : r_target + TapOne;
      OpDec:         w_cmd_target = (r_target == '0) ? r_target : r_target - TapOne;
      default:       w_cmd_target = r_target;
    endcase
    w_new_target = w_accept ? w_cmd_target : r_target;

    // Target is stable from BREAK entry through MAKE, so this is the direction at MAKE entry.
    if (r_jump)                 w_step_pos = r_target;
    else if (r_target > r_pos)  w_step_pos = r_pos + TapOne;
    else if (r_target < r_pos)  w_step_pos = r_pos - TapOne;
    else                        w_step_pos = r_pos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_pos    <= '0;
      r_target <= '0;
      r_tap_en <= OneHot0;
      r_timer  <= '0;
      r_bbm    <= '0;
      r_jump   <= 1'b0;
    end else if (i_ena) begin
      r_target <= w_new_target;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_new_target != r_pos) begin
              r_state  <= StBreak;
              r_bbm    <= BW'(BBM_CYCLES - 1);
              r_tap_en <= '0;
              r_jump   <= w_is_jump;
            end else begin
              r_jump <= 1'b0;
            end
          end
        end
        StWait: begin
          if (w_is_jump && (w_new_target != r_pos)) begin
            r_state  <= StBreak;
            r_bbm    <= BW'(BBM_CYCLES - 1);
            r_tap_en <= '0;
            r_jump   <= 1'b1;
          end else if (w_new_target == r_pos) begin
            r_state <= StIdle;
            r_jump  <= 1'b0;
          end else if (r_timer == '0) begin
            r_state  <= StBreak;
            r_bbm    <= BW'(BBM_CYCLES - 1);
            r_tap_en <= '0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        StBreak: begin
          if (r_bbm == '0) begin
            r_state  <= StMake;
            r_pos    <= w_step_pos;
            r_tap_en <= OneHot0 << w_step_pos;
            r_jump   <= 1'b0;
          end else begin
            r_bbm <= r_bbm - BW'(1);
          end
        end
        StMake: begin
          if (r_pos == r_target) begin
            r_state <= StIdle;
          end else begin
            r_state <= StWait;
            r_timer <= TW'(STEP_DIV - 1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_ready = w_ready;
  assign o_tap_en      = r_tap_en;
  assign o_wiper_pos   = r_pos;
  assign o_target      = r_target;
  assign o_busy        = (r_state != StIdle);
  assign o_at_target   = (r_state == StIdle) && (r_pos == r_target);

endmodule

// File: tb/tb_digipot_wiper_sequencer.sv
// Self-checking bench for digipot_wiper_sequencer with TAP_BITS=4, STEP_DIV=4, BBM_CYCLES=2.
module tb_digipot_wiper_sequencer;

  localparam int unsigned TAP_BITS = 4;
  localparam int unsigned STEP_DIV = 4;
  localparam int unsigned BBM      = 2;
  localparam int unsigned NTAP     = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b1;
  logic [NTAP-1:0] tap_en;
  logic [3:0]      wiper_pos;
  logic [3:0]      target;
  logic            busy;
  logic            at_target;

  digipot_wiper_sequencer_if #(.TAP_BITS(TAP_BITS)) cmd_if ();

  digipot_wiper_sequencer #(
    .TAP_BITS  (TAP_BITS),
    .STEP_DIV  (STEP_DIV),
    .BBM_CYCLES(BBM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ena      (ena),
    .cmd        (cmd_if.slave),
    .o_tap_en   (tap_en),
    .o_wiper_pos(wiper_pos),
    .o_target   (target),
    .o_busy     (busy),
    .o_at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int         data;
    int         exp_tgt;
    int         exp_pos;
    int         exp_cyc;   // negedge samples after accept until busy is first low
    int         exp_brk;   // samples with all taps open
  } vec_t;

  typedef struct {
    int tgt;
    int pos;
    int cyc;
    int brk;
  } exp_t;

  vec_t vecs[17];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_if.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_if.cmd_ready) check("ready_timeout", 0, 1);
  endtask

  // Present one command at a negedge; it is accepted on the following posedge.
  task automatic send(input logic [1:0] op, input int data);
    wait_ready();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = 4'(data);
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(output int cyc, output int brk);
    cyc = 0;
    brk = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (tap_en == '0) begin
        brk++;
        check("ready_in_break", int'(cmd_if.cmd_ready), 0);
      end
      if ($countones(tap_en) > 1) check("multi_hot", int'(tap_en), 0);
    end while (busy && cyc < 300);
    if (busy) check("idle_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, brk, prev;
    exp_t e;
    int seen[$];

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = '0;

    //          op     data tgt pos cyc brk
    vecs[0]  = '{2'b00, 3,   3,  3,  18, 6};
    vecs[1]  = '{2'b01, 0,   4,  4,  4,  2};
    vecs[2]  = '{2'b10, 0,   3,  3,  4,  2};
    vecs[3]  = '{2'b11, 15,  15, 15, 4,  2};
    vecs[4]  = '{2'b01, 0,   15, 15, 1,  0};
    vecs[5]  = '{2'b01, 0,   15, 15, 1,  0};
    vecs[6]  = '{2'b01, 0,   15, 15, 1,  0};
    vecs[7]  = '{2'b00, 13,  13, 13, 11, 4};
    vecs[8]  = '{2'b11, 2,   2,  2,  4,  2};
    vecs[9]  = '{2'b11, 12,  12, 12, 4,  2};
    vecs[10] = '{2'b11, 0,   0,  0,  4,  2};
    vecs[11] = '{2'b10, 0,   0,  0,  1,  0};
    vecs[12] = '{2'b00, 0,   0,  0,  1,  0};
    vecs[13] = '{2'b11, 0,   0,  0,  1,  0};
    vecs[14] = '{2'b00, 1,   1,  1,  4,  2};
    vecs[15] = '{2'b11, 9,   9,  9,  4,  2};
    vecs[16] = '{2'b11, 0,   0,  0,  4,  2};

    // Reset state
    #12;
    check("rst_tap_en", int'(tap_en), 1);
    check("rst_pos", int'(wiper_pos), 0);
    check("rst_target", int'(target), 0);
    check("rst_at_target", int'(at_target), 1);
    check("rst_ready", int'(cmd_if.cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven commands through the scoreboard
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].data);
      sb_q.push_back('{vecs[i].exp_tgt, vecs[i].exp_pos, vecs[i].exp_cyc, vecs[i].exp_brk});
      run_until_idle(cyc, brk);
      e = sb_q.pop_front();
      check($sformatf("v%0d_target", i), int'(target), e.tgt);
      check($sformatf("v%0d_pos", i), int'(wiper_pos), e.pos);
      check($sformatf("v%0d_tap_en", i), int'(tap_en), 1 << e.pos);
      check($sformatf("v%0d_at_target", i), int'(at_target), 1);
      check($sformatf("v%0d_cycles", i), cyc, e.cyc);
      check($sformatf("v%0d_break_cycles", i), brk, e.brk);
    end

    // Reversal mid-ramp: SET 8, then SET 0 once in WAIT at pos 2
    send(2'b00, 8);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(cmd_if.cmd_ready && busy && wiper_pos == 4'd2) && n < 300);
    end
    check("rev_reach_pos2", int'(wiper_pos), 2);
    send(2'b00, 0);
    prev = 2;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (int'(wiper_pos) != prev) begin
        seen.push_back(int'(wiper_pos));
        prev = int'(wiper_pos);
      end
    end while (busy && cyc < 300);
    check("rev_step_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("rev_first_make", seen[0], 1);
      check("rev_second_make", seen[1], 0);
    end
    check("rev_target", int'(target), 0);
    check("rev_at_target", int'(at_target), 1);

    // ena freeze in WAIT: SET 2 from 0, hold ena low 10 cycles at pos 1
    send(2'b00, 2);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(cmd_if.cmd_ready && busy) && n < 300);
    end
    ena = 1'b0;
    #1;
    check("frz_ready_low", int'(cmd_if.cmd_ready), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("frz_ready", int'(cmd_if.cmd_ready), 0);
      check("frz_tap_en", int'(tap_en), 16'h0002);
      check("frz_busy", int'(busy), 1);
    end
    ena = 1'b1;
    run_until_idle(cyc, brk);
    check("frz_resume_cycles", cyc, 7);
    check("frz_resume_brk", brk, 2);
    check("frz_pos", int'(wiper_pos), 2);

    // Asynchronous reset while in BREAK
    send(2'b00, 5);
    @(negedge clk);
    check("rstb_in_break", int'(tap_en), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstb_tap_en", int'(tap_en), 1);
    check("rstb_pos", int'(wiper_pos), 0);
    check("rstb_target", int'(target), 0);
    check("rstb_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstb_at_target", int'(at_target), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
